// File: rtl/ika2151_dacout.sv
// -----------------------------------------------------------------------------
// ika2151_dacout
//
// Serial DAC output stage. Once per 32-slot frame the signed 16-bit left and
// right accumulator sums are sampled, converted to the YM3012-style float
// format (10-bit mantissa, 3-bit exponent, 3 zero pad bits at the bottom) and
// shifted out LSB-first on one serial line, right word first.
//
// Every register advances only on posedge i_EMUCLK while i_phi1_NCEN_n is low.
//
// Optional feature macro: IKA2151_DACOUT_LINEAR_EN
//   When defined, o_LIN_L / o_LIN_R expose the signed value the DAC will
//   reconstruct from each float word. When undefined, those ports and their
//   registers are absent and the serial behaviour is unchanged.
//
// Ports
//   i_EMUCLK       in   1  emulator master clock
//   i_MRST_n       in   1  asynchronous active-low reset
//   i_phi1_NCEN_n  in   1  phi1 negative-edge clock enable, active low
//   i_CYCLE_31     in   1  frame sync pulse (one enabled cycle in 32)
//   i_ACC_L        in  16  signed left accumulator sum
//   i_ACC_R        in  16  signed right accumulator sum
//   o_SO           out  1  serial data, bit 0 of the shift register
//   o_LIN_L        out 16  reconstructed left value (LINEAR_EN only)
//   o_LIN_R        out 16  reconstructed right value (LINEAR_EN only)
//   o_SYNC_ERR     out  1  sticky frame-sync error flag
// -----------------------------------------------------------------------------
module ika2151_dacout (
    input  logic        i_EMUCLK,
    input  logic        i_MRST_n,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_CYCLE_31,
    input  logic [15:0] i_ACC_L,
    input  logic [15:0] i_ACC_R,
    output logic        o_SO,
`ifdef IKA2151_DACOUT_LINEAR_EN
    output logic [15:0] o_LIN_L,
    output logic [15:0] o_LIN_R,
`endif
    output logic        o_SYNC_ERR
);

    typedef enum logic [0:0] {
        ST_UNSYNC  = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Float conversion helpers
    // -------------------------------------------------------------------------

    // Smallest exponent e in 1..7 for which v[15:8+e] are all copies of the
    // sign bit. diff_s[i] flags a disagreement between v[9+i] and the sign.
    function automatic logic [2:0] float_exp(input logic [15:0] v);
        logic [5:0] diff_s;
        logic [2:0] e_s;
        diff_s = v[14:9] ^ {6{v[15]}};
        if (diff_s[5:0] == 6'd0) begin
            e_s = 3'd1;
        end else if (diff_s[5:1] == 5'd0) begin
            e_s = 3'd2;
        end else if (diff_s[5:2] == 4'd0) begin
            e_s = 3'd3;
        end else if (diff_s[5:3] == 3'd0) begin
            e_s = 3'd4;
        end else if (diff_s[5:4] == 2'd0) begin
            e_s = 3'd5;
        end else if (diff_s[5] == 1'b0) begin
            e_s = 3'd6;
        end else begin
            e_s = 3'd7;
        end
        return e_s;
    endfunction

    // Mantissa is the 10-bit window v[8+e:e-1].
    function automatic logic [9:0] float_mant(input logic [15:0] v,
                                              input logic [2:0]  e);
        logic [9:0] m_s;
        case (e)
            3'd1:    m_s = v[9:0];
            3'd2:    m_s = v[10:1];
            3'd3:    m_s = v[11:2];
            3'd4:    m_s = v[12:3];
            3'd5:    m_s = v[13:4];
            3'd6:    m_s = v[14:5];
            3'd7:    m_s = v[15:6];
            default: m_s = v[9:0];
        endcase
        return m_s;
    endfunction

    // Serial word: exponent on top, mantissa, three zero pad bits at the LSBs.
    function automatic logic [15:0] float_word(input logic [15:0] v);
        logic [2:0] e_s;
        e_s = float_exp(v);
        return {e_s, float_mant(v, e_s), 3'b000};
    endfunction

`ifdef IKA2151_DACOUT_LINEAR_EN
    // Value the DAC reconstructs: sign-extended mantissa scaled by 2^(exp-1).
    // The mantissa window always fits in 16 bits after the shift.
    function automatic logic [15:0] float_lin(input logic [15:0] word);
        logic [15:0] ext_s;
        logic [2:0]  e_s;
        e_s   = word[15:13];
        ext_s = {{6{word[12]}}, word[12:3]};
        return ext_s << (e_s - 3'd1);
    endfunction
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [4:0]  slot_q,  slot_d;
    logic [31:0] sr_q,    sr_d;
    logic        err_q,   err_d;
    logic [15:0] word_l_s;
    logic [15:0] word_r_s;
    logic        ce_s;
`ifdef IKA2151_DACOUT_LINEAR_EN
    logic [15:0] lin_l_q, lin_l_d;
    logic [15:0] lin_r_q, lin_r_d;
`endif

    assign ce_s = ~i_phi1_NCEN_n;

    // Float words are formed combinationally from the live accumulator sums;
    // they are only captured on the sync edge.
    always_comb begin
        word_l_s = float_word(i_ACC_L);
        word_r_s = float_word(i_ACC_R);
    end

    // Next-state logic: frame reload on sync, otherwise shift and count slots.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        sr_d    = sr_q;
        err_d   = err_q;
`ifdef IKA2151_DACOUT_LINEAR_EN
        lin_l_d = lin_l_q;
        lin_r_d = lin_r_q;
`endif
        if (ce_s) begin
            if (i_CYCLE_31) begin
                // Right word sits in the low half so it leaves first.
                sr_d    = {word_l_s, word_r_s};
                slot_d  = 5'd0;
                state_d = ST_RUNNING;
`ifdef IKA2151_DACOUT_LINEAR_EN
                lin_l_d = float_lin(word_l_s);
                lin_r_d = float_lin(word_r_s);
`endif
                case (state_q)
                    // Early sync truncates the running frame.
                    ST_RUNNING: begin
                        if (slot_q != 5'd31) begin
                            err_d = 1'b1;
                        end else begin
                            err_d = err_q;
                        end
                    end
                    ST_UNSYNC: err_d = err_q;
                    default:   err_d = 1'b1;
                endcase
            end else begin
                sr_d   = {1'b0, sr_q[31:1]};
                slot_d = slot_q + 5'd1;
                case (state_q)
                    // Slot 31 passed without a sync: frame lock is lost.
                    ST_RUNNING: begin
                        if (slot_q == 5'd31) begin
                            state_d = ST_UNSYNC;
                            err_d   = 1'b1;
                        end else begin
                            state_d = ST_RUNNING;
                        end
                    end
                    ST_UNSYNC: state_d = ST_UNSYNC;
                    default: begin
                        state_d = ST_UNSYNC;
                        err_d   = 1'b1;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_EMUCLK or negedge i_MRST_n) begin
        if (!i_MRST_n) begin
            state_q <= ST_UNSYNC;
            slot_q  <= 5'd0;
            sr_q    <= 32'd0;
            err_q   <= 1'b0;
`ifdef IKA2151_DACOUT_LINEAR_EN
            lin_l_q <= 16'd0;
            lin_r_q <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            sr_q    <= sr_d;
            err_q   <= err_d;
`ifdef IKA2151_DACOUT_LINEAR_EN
            lin_l_q <= lin_l_d;
            lin_r_q <= lin_r_d;
`endif
        end
    end

    assign o_SO       = sr_q[0];
    assign o_SYNC_ERR = err_q;
`ifdef IKA2151_DACOUT_LINEAR_EN
    assign o_LIN_L    = lin_l_q;
    assign o_LIN_R    = lin_r_q;
`endif

endmodule

// File: tb/tb_ika2151_dacout.sv
// -----------------------------------------------------------------------------
// tb_ika2151_dacout
//
// Self-checking bench for ika2151_dacout. A behavioural model tracks frame
// lock, the sticky error flag and the expected serial bit from the float
// values computed arithmetically; directed frames from the test plan are
// also captured bit by bit and compared against fixed words.
// -----------------------------------------------------------------------------
module tb_ika2151_dacout;

    logic        clk;
    logic        rst_n;
    logic        ncen_n;
    logic        cyc31;
    logic [15:0] acc_l;
    logic [15:0] acc_r;
    logic        so;
    logic        sync_err;
    logic [15:0] lin_l;
    logic [15:0] lin_r;

    int n_checks;
    int n_fail;

    // Model state
    logic        m_running;
    logic        m_err;
    int          m_cnt;
    int          m_since;
    logic [31:0] m_bits;
    logic [15:0] m_lin_l;
    logic [15:0] m_lin_r;

    ika2151_dacout dut (
        .i_EMUCLK      (clk),
        .i_MRST_n      (rst_n),
        .i_phi1_NCEN_n (ncen_n),
        .i_CYCLE_31    (cyc31),
        .i_ACC_L       (acc_l),
        .i_ACC_R       (acc_r),
        .o_SO          (so),
`ifdef IKA2151_DACOUT_LINEAR_EN
        .o_LIN_L       (lin_l),
        .o_LIN_R       (lin_r),
`endif
        .o_SYNC_ERR    (sync_err)
    );

`ifndef IKA2151_DACOUT_LINEAR_EN
    assign lin_l = 16'd0;
    assign lin_r = 16'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Exponent: smallest e whose (9+e)-bit signed range holds the value.
    function automatic int ref_exp(input logic [15:0] v);
        int sv;
        sv = int'($signed(v));
        for (int e = 1; e <= 7; e++) begin
            if (sv >= -(1 << (8 + e)) && sv < (1 << (8 + e))) return e;
        end
        return 7;
    endfunction

    function automatic int ref_mant(input logic [15:0] v);
        int sv;
        sv = int'($signed(v));
        return (sv >>> (ref_exp(v) - 1)) & 1023;
    endfunction

    function automatic logic [15:0] ref_word(input logic [15:0] v);
        int w;
        w = ref_exp(v) * 8192 + ref_mant(v) * 8;
        return w[15:0];
    endfunction

    function automatic logic [15:0] ref_lin(input logic [15:0] v);
        int m;
        int r;
        m = ref_mant(v);
        if (m >= 512) m = m - 1024;
        r = m * (1 << (ref_exp(v) - 1));
        return r[15:0];
    endfunction

    task automatic model_reset();
        m_running = 1'b0;
        m_err     = 1'b0;
        m_cnt     = 0;
        m_since   = 32;
        m_bits    = 32'd0;
        m_lin_l   = 16'd0;
        m_lin_r   = 16'd0;
    endtask

    task automatic model_update(input logic sync, input logic [15:0] l,
                                input logic [15:0] r);
        if (sync) begin
            if (m_running && m_cnt != 31) m_err = 1'b1;
            m_running = 1'b1;
            m_cnt     = 0;
            m_since   = 0;
            m_bits    = {ref_word(l), ref_word(r)};
            m_lin_l   = ref_lin(l);
            m_lin_r   = ref_lin(r);
        end else begin
            if (m_running && m_cnt == 31) begin
                m_running = 1'b0;
                m_err     = 1'b1;
            end
            m_cnt   = (m_cnt + 1) % 32;
            m_since = m_since + 1;
        end
    endtask

    function automatic logic model_so();
        if (m_since < 32) return m_bits[m_since];
        return 1'b0;
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, "_so"}, {31'd0, so}, {31'd0, model_so()});
        check_val({tag, "_err"}, {31'd0, sync_err}, {31'd0, m_err});
`ifdef IKA2151_DACOUT_LINEAR_EN
        check_val({tag, "_linl"}, {16'd0, lin_l}, {16'd0, m_lin_l});
        check_val({tag, "_linr"}, {16'd0, lin_r}, {16'd0, m_lin_r});
`endif
    endtask

    // One EMUCLK cycle: drive, clock, sample 1 time unit after the edge.
    task automatic step(input string tag, input logic en, input logic sync,
                        input logic [15:0] l, input logic [15:0] r);
        ncen_n = ~en;
        cyc31  = sync;
        acc_l  = l;
        acc_r  = r;
        @(posedge clk);
        #1;
        if (en) model_update(sync, l, r);
        check_outputs(tag);
    endtask

    // Sync followed by 31 shift cycles; freeze_at >= 0 inserts 5 disabled
    // cycles (with sync held high) after that many shifts.
    task automatic run_frame(input string tag, input logic [15:0] l,
                             input logic [15:0] r, input int freeze_at,
                             output logic [31:0] cap);
        cap = 32'd0;
        step(tag, 1'b1, 1'b1, l, r);
        cap[0] = so;
        for (int k = 1; k < 32; k++) begin
            if (k - 1 == freeze_at) begin
                for (int f = 0; f < 5; f++) begin
                    step({tag, "_frz"}, 1'b0, 1'b1, 16'h1234, 16'h5678);
                end
            end
            step(tag, 1'b1, 1'b0, l, r);
            cap[k] = so;
        end
    endtask

    initial begin
        logic [31:0] cap;
        logic        en;
        logic        sync;
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst_n  = 1'b0;
        ncen_n = 1'b1;
        cyc31  = 1'b0;
        acc_l  = 16'd0;
        acc_r  = 16'd0;
        #3;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle before any sync: zeros, no error.
        for (int i = 0; i < 3; i++) step("idle", 1'b1, 1'b0, 16'd0, 16'd0);

        // Basic frame with small positive values.
        run_frame("frame1", 16'h0200, 16'h0100, -1, cap);
        check_val("frame1_words", cap, 32'h4800_2800);
`ifdef IKA2151_DACOUT_LINEAR_EN
        check_val("frame1_linl", {16'd0, lin_l}, 32'h0000_0200);
        check_val("frame1_linr", {16'd0, lin_r}, 32'h0000_0100);
`endif

        // Full-scale extremes.
        run_frame("frame2", 16'h8000, 16'h7FFF, -1, cap);
        check_val("frame2_words", cap, 32'hF000_EFF8);
`ifdef IKA2151_DACOUT_LINEAR_EN
        check_val("frame2_linl", {16'd0, lin_l}, 32'h0000_8000);
        check_val("frame2_linr", {16'd0, lin_r}, 32'h0000_7FC0);
`endif

        // Negative boundary values, with a 5-cycle enable freeze mid-frame.
        run_frame("frame3", 16'hFDFF, 16'hFE00, 10, cap);
        check_val("frame3_words", cap, 32'h57F8_3000);
        check_val("no_err_yet", {31'd0, sync_err}, 32'd0);

        // Reset mid-frame while a 1 is on the line.
        step("pre_rst", 1'b1, 1'b1, 16'h8000, 16'h7FFF);
        for (int k = 0; k < 5; k++) step("pre_rst", 1'b1, 1'b0, 16'h0, 16'h0);
        check_val("pre_rst_so_high", {31'd0, so}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step("post_rst", 1'b1, 1'b0, 16'h0, 16'h0);

        // Missing sync at slot 31: lock lost, line goes quiet, then recovers.
        run_frame("miss", 16'h1234, 16'h4321, -1, cap);
        step("miss_edge", 1'b1, 1'b0, 16'h0, 16'h0);
        check_val("miss_err", {31'd0, sync_err}, 32'd1);
        for (int k = 0; k < 10; k++) step("unsync", 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
        run_frame("relock", 16'h0200, 16'h0100, -1, cap);
        check_val("relock_words", cap, 32'h4800_2800);

        // Early sync at slot 20 truncates and restarts.
        reset_and_early_sync();

        // Randomized traffic with occasional early/missing syncs and stalls.
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 4) != 0);
            if (!en) begin
                sync = 1'($urandom_range(0, 1));
            end else if (m_cnt == 31) begin
                sync = ($urandom_range(0, 19) != 0);
            end else begin
                sync = ($urandom_range(0, 59) == 0);
            end
            step("rand", en, sync, 16'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    task automatic reset_and_early_sync();
        logic [31:0] cap;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst2");
        @(negedge clk);
        rst_n = 1'b1;
        step("early_a", 1'b1, 1'b1, 16'h7FFF, 16'h7FFF);
        for (int k = 0; k < 20; k++) step("early_b", 1'b1, 1'b0, 16'h0, 16'h0);
        check_val("early_err_before", {31'd0, sync_err}, 32'd0);
        run_frame("early", 16'hFDFF, 16'h0100, -1, cap);
        check_val("early_words", cap, 32'h57F8_2800);
        check_val("early_err", {31'd0, sync_err}, 32'd1);
    endtask

endmodule
